// File: rtl/memory_store_unit.sv
// memory_store_unit
//   Store path toward the data memory. It accepts one store request with a
//   byte address, right-justified data and an access width. It places the
//   data onto the 32-bit memory byte lanes and builds the byte enables. The
//   request goes out as one word-aligned write beat, or as two beats when
//   the store crosses a word boundary.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_addr          byte address, any alignment
//   req_data          store data, right-justified
//   req_width         BYTE / HALF / WORD
//   mem_valid/ready   write-beat handshake toward memory
//   mem_addr          word-aligned beat address
//   mem_data          lane-aligned write data (disabled lanes are zero)
//   mem_byte_en       lane enables, bit i covers mem_data[8i+7:8i]
//   busy              request in flight
//   done              one-cycle pulse after the final beat is accepted

package memory_store_unit_pkg;
  localparam int WORD_MASK = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memory_access_width_t;
endpackage

module memory_store_unit
  import memory_store_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [WORD_MASK-1:0]  req_addr,
  input  logic [WORD_MASK-1:0]  req_data,
  input  memory_access_width_t  req_width,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [WORD_MASK-1:0]  mem_addr,
  output logic [WORD_MASK-1:0]  mem_data,
  output logic [3:0]            mem_byte_en,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_t;

  function automatic logic [3:0] width_mask(input memory_access_width_t w);
    case (w)
      BYTE:    width_mask = 4'b0001;
      HALF:    width_mask = 4'b0011;
      default: width_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [WORD_MASK-1:0] mask_data(input logic [WORD_MASK-1:0] d,
                                                     input memory_access_width_t w);
    case (w)
      BYTE:    mask_data = {24'h0, d[7:0]};
      HALF:    mask_data = {16'h0, d[15:0]};
      default: mask_data = d;
    endcase
  endfunction

  state_t               state_q, state_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [WORD_MASK-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_MASK-1:0] mem_data_q, mem_data_d;
  logic [3:0]           mem_be_q, mem_be_d;
  logic                 done_q, done_d;
  // Second-beat payload, held while beat 0 is outstanding.
  logic [WORD_MASK-1:0] hi_addr_q, hi_addr_d;
  logic [WORD_MASK-1:0] hi_data_q, hi_data_d;
  logic [3:0]           hi_be_q, hi_be_d;

  logic [63:0]          lane_data;
  logic [7:0]           lane_en;

  // Lane images spanning two words; the upper half feeds beat 1.
  assign lane_data = {32'h0, mask_data(req_data, req_width)} << {req_addr[1:0], 3'b000};
  assign lane_en   = {4'h0, width_mask(req_width)} << req_addr[1:0];

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_byte_en = mem_be_q;
  assign done        = done_q;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_be_d    = mem_be_q;
    hi_addr_d   = hi_addr_q;
    hi_data_d   = hi_data_q;
    hi_be_d     = hi_be_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = BEAT0;
          mem_valid_d = 1'b1;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_data_d  = lane_data[31:0];
          mem_be_d    = lane_en[3:0];
          // Wraps modulo 2^32 at the top of the address space.
          hi_addr_d   = {req_addr[31:2], 2'b00} + 32'd4;
          hi_data_d   = lane_data[63:32];
          hi_be_d     = lane_en[7:4];
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (hi_be_q != 4'h0) begin
            // Swap straight to beat 1 so mem_valid stays high without a bubble.
            state_d    = BEAT1;
            mem_addr_d = hi_addr_q;
            mem_data_d = hi_data_q;
            mem_be_d   = hi_be_q;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            mem_addr_d  = '0;
            mem_data_d  = '0;
            mem_be_d    = '0;
            done_d      = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = '0;
          mem_data_d  = '0;
          mem_be_d    = '0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_be_q    <= '0;
      hi_addr_q   <= '0;
      hi_data_q   <= '0;
      hi_be_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_be_q    <= mem_be_d;
      hi_addr_q   <= hi_addr_d;
      hi_data_q   <= hi_data_d;
      hi_be_q     <= hi_be_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_memory_store_unit.sv
module tb_memory_store_unit;
  import memory_store_unit_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid;
  logic                 req_ready;
  logic [31:0]          req_addr;
  logic [31:0]          req_data;
  memory_access_width_t req_width;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_data;
  logic [3:0]           mem_byte_en;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  // Expected beats from the byte-level reference model.
  int          exp_n;
  logic [31:0] exp_addr [2];
  logic [31:0] exp_data [2];
  logic [3:0]  exp_be   [2];

  memory_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_width  (req_width),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_byte_en(mem_byte_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk the stored bytes one by one; each byte lands in the word holding its
  // address, at the lane given by the low address bits.
  task automatic model(input logic [31:0] addr, input logic [31:0] data,
                       input memory_access_width_t w);
    int nb;
    logic [31:0] a;
    logic [31:0] wa;
    int lane;
    nb = (w == BYTE) ? 1 : (w == HALF) ? 2 : 4;
    exp_n = 0;
    exp_data[0] = '0; exp_data[1] = '0;
    exp_be[0] = '0;   exp_be[1] = '0;
    exp_addr[0] = '0; exp_addr[1] = '0;
    for (int k = 0; k < nb; k++) begin
      a    = addr + k;
      wa   = a & 32'hFFFF_FFFC;
      lane = int'(a & 32'h3);
      if (exp_n == 0 || exp_addr[exp_n-1] != wa) begin
        exp_addr[exp_n] = wa;
        exp_n++;
      end
      exp_data[exp_n-1][8*lane +: 8] = data[8*k +: 8];
      exp_be[exp_n-1][lane] = 1'b1;
    end
  endtask

  // Called and returns at a falling edge. stall < 0 picks a random stall.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input memory_access_width_t w, input int stall);
    int s;
    model(addr, data, w);
    chk("req_ready_idle", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_width = w;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    chk("done_clear", {63'h0, done}, 64'h0);
    for (int b = 0; b < exp_n; b++) begin
      s = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
      for (int c = 0; c <= s; c++) begin
        mem_ready = (c == s);
        chk("mem_valid", {63'h0, mem_valid}, 64'h1);
        chk("mem_addr", {32'h0, mem_addr}, {32'h0, exp_addr[b]});
        chk("mem_data", {32'h0, mem_data}, {32'h0, exp_data[b]});
        chk("mem_byte_en", {60'h0, mem_byte_en}, {60'h0, exp_be[b]});
        chk("req_ready_busy", {62'h0, req_ready, busy}, 64'h1);
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    chk("done_pulse", {63'h0, done}, 64'h1);
    chk("mem_valid_end", {63'h0, mem_valid}, 64'h0);
    chk("busy_end", {63'h0, busy}, 64'h0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    req_width = WORD;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {mem_valid, mem_addr, mem_data[27:0], mem_byte_en, done, busy},
        64'h0);
    chk("rst_req_ready", {63'h0, req_ready}, 64'h1);
    rst = 1'b0;
    @(negedge clk);

    do_store(32'h0000_0100, 32'hDEAD_BEEF, WORD, 0);
    do_store(32'h0000_0103, 32'hFFFF_FFA5, BYTE, 0);
    do_store(32'h0000_0203, 32'h0000_1234, HALF, 0);
    do_store(32'h0000_0301, 32'h1122_3344, WORD, 3);
    do_store(32'hFFFF_FFFE, 32'hCAFE_BABE, WORD, 0);
    chk("wrap_model", {32'h0, exp_addr[1]}, 64'h0);

    // Reset while beat 1 of a crossing store is stalled.
    model(32'h0000_0402, 32'h5566_7788, WORD);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0402;
    req_data  = 32'h5566_7788;
    req_width = WORD;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("split_beat1_addr", {32'h0, mem_addr}, {32'h0, exp_addr[1]});
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    chk("rst_mid_outputs", {mem_valid, mem_addr, mem_data[27:0], mem_byte_en, done, busy},
        64'h0);
    chk("rst_mid_req_ready", {63'h0, req_ready}, 64'h1);
    @(negedge clk);
    chk("rst_mid_no_done", {63'h0, done}, 64'h0);
    do_store(32'h0000_0500, 32'h0BAD_F00D, WORD, 0);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      do_store(ra, $urandom, memory_access_width_t'($urandom_range(0, 2)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
